// File: rtl/fetch_pkg.sv
/*----------------------------------------------------------------------------
 * fetch_pkg : shared types and constants for the fetch controller
 * Revision  : 1.0
 *--------------------------------------------------------------------------*/
`default_nettype none

package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

  localparam logic [1:0] PCSRC_PLUS4   = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH  = 2'b01;
  localparam logic [1:0] PCSRC_JALR    = 2'b10;
  localparam logic [1:0] PCSRC_ILLEGAL = 2'b11;

  function automatic logic is_redirect(input logic [1:0] sel);
    return (sel == PCSRC_BRANCH) || (sel == PCSRC_JALR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
/*----------------------------------------------------------------------------
 * sat_counter : up-counter that sticks at all-ones instead of wrapping
 * Revision    : 1.0
 *--------------------------------------------------------------------------*/
`default_nettype none

module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/fetch_ctrl.sv
/*----------------------------------------------------------------------------
 * fetch_ctrl : instruction fetch sequencer with hazard/redirect handling
 * Revision   : 1.0
 *--------------------------------------------------------------------------*/
`default_nettype none

module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 trigger,
  input  logic                 imem_ready,
  input  logic [1:0]           pcsrc_e,
  input  logic                 load_use,
  output logic [1:0]           pcsrc,
  output logic                 pc_en,
  output logic                 imem_req,
  output logic                 stall_d,
  output logic                 flush_d,
  output logic                 flush_e,
  output logic [CNT_WIDTH-1:0] redirect_cnt,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic                 err
);

  fetch_state_e state_q, state_d;
  logic         halt_pending_q, halt_pending_d;
  logic         err_q, err_d;
  logic         redirect_inc;
  logic         stall_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      halt_pending_q <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      halt_pending_q <= halt_pending_d;
      err_q          <= err_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    halt_pending_d = halt_pending_q;
    pcsrc          = PCSRC_PLUS4;
    pc_en          = 1'b0;
    imem_req       = 1'b0;
    stall_d        = 1'b0;
    flush_d        = 1'b0;
    flush_e        = 1'b0;
    redirect_inc   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        flush_d = 1'b1;
        flush_e = 1'b1;
        if (trigger) state_d = ST_FETCH;
      end

      ST_FETCH: begin
        imem_req = 1'b1;
        if (is_redirect(pcsrc_e)) begin
          pcsrc        = pcsrc_e;
          pc_en        = 1'b1;
          flush_d      = 1'b1;
          flush_e      = 1'b1;
          redirect_inc = 1'b1;
          // The redirect always lands; a simultaneous halt then follows the normal halt path.
          if (!imem_ready) begin
            state_d        = ST_DRAIN;
            halt_pending_d = !trigger;
          end else if (!trigger) begin
            state_d = ST_IDLE;
          end
        end else if (!trigger) begin
          stall_d = !imem_ready;
          if (imem_ready) begin
            state_d = ST_IDLE;
          end else begin
            state_d        = ST_DRAIN;
            halt_pending_d = 1'b1;
          end
        end else if (!imem_ready) begin
          stall_d = 1'b1;
        end else if (load_use) begin
          stall_d = 1'b1;
          flush_e = 1'b1;
        end else begin
          pc_en = 1'b1;
        end
      end

      ST_DRAIN: begin
        flush_d = 1'b1;
        if (imem_ready) begin
          state_d        = halt_pending_q ? ST_IDLE : ST_FETCH;
          halt_pending_d = 1'b0;
        end
      end

      default: begin
        state_d        = ST_IDLE;
        halt_pending_d = 1'b0;
      end
    endcase
  end

  assign stall_inc = (state_q == ST_FETCH) && !pc_en;
  assign err_d     = err_q || (pcsrc_e == PCSRC_ILLEGAL);
  assign err       = err_q;

  sat_counter #(.WIDTH(CNT_WIDTH)) u_redirect_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (redirect_inc),
    .count (redirect_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

endmodule

`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
/*----------------------------------------------------------------------------
 * tb_fetch_ctrl : randomized self-checking bench against a behavioural model
 * Revision      : 1.0
 *--------------------------------------------------------------------------*/
`default_nettype none

module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        trigger = 1'b0;
  logic        imem_ready = 1'b0;
  logic [1:0]  pcsrc_e = 2'b00;
  logic        load_use = 1'b0;

  logic [1:0]  pcsrc_a, pcsrc_b;
  logic        pc_en_a, pc_en_b, imem_req_a, imem_req_b;
  logic        stall_d_a, stall_d_b, flush_d_a, flush_d_b, flush_e_a, flush_e_b;
  logic        err_a, err_b;
  logic [15:0] red_a, stl_a;
  logic [3:0]  red_b, stl_b;

  int n_checks = 0;
  int n_fail   = 0;

  // model state: 0 idle, 1 fetching, 2 discarding an abandoned response
  int m_mode  = 0;
  bit m_halt  = 1'b0;
  int m_red   = 0;
  int m_stall = 0;
  bit m_err   = 1'b0;

  always #5 clk = ~clk;

  fetch_ctrl #(.CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .trigger(trigger), .imem_ready(imem_ready),
    .pcsrc_e(pcsrc_e), .load_use(load_use), .pcsrc(pcsrc_a), .pc_en(pc_en_a),
    .imem_req(imem_req_a), .stall_d(stall_d_a), .flush_d(flush_d_a),
    .flush_e(flush_e_a), .redirect_cnt(red_a), .stall_cnt(stl_a), .err(err_a)
  );

  fetch_ctrl #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .trigger(trigger), .imem_ready(imem_ready),
    .pcsrc_e(pcsrc_e), .load_use(load_use), .pcsrc(pcsrc_b), .pc_en(pc_en_b),
    .imem_req(imem_req_b), .stall_d(stall_d_b), .flush_d(flush_d_b),
    .flush_e(flush_e_b), .redirect_cnt(red_b), .stall_cnt(stl_b), .err(err_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic check_regs();
    chk("redirect_cnt16", {16'd0, red_a}, sat(m_red, 65535));
    chk("stall_cnt16",    {16'd0, stl_a}, sat(m_stall, 65535));
    chk("redirect_cnt4",  {28'd0, red_b}, sat(m_red, 15));
    chk("stall_cnt4",     {28'd0, stl_b}, sat(m_stall, 15));
    chk("err",  {31'd0, err_a}, {31'd0, m_err});
    chk("err4", {31'd0, err_b}, {31'd0, m_err});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    m_mode = 0; m_halt = 1'b0; m_red = 0; m_stall = 0; m_err = 1'b0;
    chk("reset_ctl",  {25'd0, pcsrc_a, pc_en_a, imem_req_a, stall_d_a, flush_d_a, flush_e_a}, 32'h03);
    check_regs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // One cycle: drive inputs, check combinational outputs, then registered state.
  task automatic cycle(input bit t, input bit r, input bit [1:0] pe, input bit lu);
    bit       redir;
    bit [6:0] exp;
    int       nmode;
    bit       nhalt;
    @(negedge clk);
    trigger = t; imem_ready = r; pcsrc_e = pe; load_use = lu;
    #1;
    redir = (pe == 2'b01) || (pe == 2'b10);
    nmode = m_mode;
    nhalt = m_halt;
    exp   = 7'b00_0_0_0_0_0;
    case (m_mode)
      0: begin
        exp = 7'b00_0_0_0_1_1;
        if (t) nmode = 1;
      end
      1: begin
        if (redir) begin
          exp = {pe, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
          m_red++;
          if (!r) begin nmode = 2; nhalt = !t; end
          else if (!t) nmode = 0;
        end else if (!t) begin
          exp = {2'b00, 1'b0, 1'b1, !r, 1'b0, 1'b0};
          if (r) nmode = 0;
          else begin nmode = 2; nhalt = 1'b1; end
        end else if (!r) exp = 7'b00_0_1_1_0_0;
        else if (lu)     exp = 7'b00_0_1_1_0_1;
        else             exp = 7'b00_1_1_0_0_0;
        if (!exp[4]) m_stall++;
      end
      default: begin
        exp = 7'b00_0_0_0_1_0;
        if (r) begin nmode = m_halt ? 0 : 1; nhalt = 1'b0; end
      end
    endcase
    if (pe == 2'b11) m_err = 1'b1;
    chk("ctl",  {25'd0, pcsrc_a, pc_en_a, imem_req_a, stall_d_a, flush_d_a, flush_e_a}, {25'd0, exp});
    chk("ctl4", {25'd0, pcsrc_b, pc_en_b, imem_req_b, stall_d_b, flush_d_b, flush_e_b}, {25'd0, exp});
    @(posedge clk);
    #1;
    m_mode = nmode;
    m_halt = nhalt;
    check_regs();
  endtask

  initial begin
    do_reset();
    // Startup: one IDLE cycle then five straight fetches.
    for (int i = 0; i < 6; i++) cycle(1, 1, 2'b00, 0);
    chk("startup_stall_cnt", {16'd0, stl_a}, 32'd0);
    for (int i = 0; i < 3; i++) cycle(1, 0, 2'b00, 0);
    chk("miss3_stall_cnt", {16'd0, stl_a}, 32'd3);
    // jalr with a miss, drain, resume
    cycle(1, 0, 2'b10, 0);
    cycle(1, 0, 2'b00, 0);
    cycle(1, 1, 2'b00, 0);
    cycle(1, 1, 2'b00, 0);
    chk("jalr_redirect_cnt", {16'd0, red_a}, 32'd1);
    // redirect beats load-use
    cycle(1, 1, 2'b01, 1);
    chk("redir_over_lu_stall", {16'd0, stl_a}, 32'd3);
    // halt during a miss, then a late response and idle hold
    cycle(1, 0, 2'b00, 0);
    cycle(0, 0, 2'b00, 0);
    cycle(0, 0, 2'b00, 0);
    cycle(0, 1, 2'b00, 0);
    cycle(0, 1, 2'b00, 0);
    // illegal select is sticky
    cycle(1, 1, 2'b11, 0);
    cycle(1, 1, 2'b11, 0);
    cycle(1, 1, 2'b00, 1);
    chk("err_sticky", {31'd0, err_a}, 32'd1);
    // redirect coincident with halt, both response outcomes
    cycle(0, 1, 2'b01, 0);
    cycle(1, 1, 2'b00, 0);
    cycle(0, 0, 2'b10, 0);
    cycle(1, 1, 2'b00, 0);
    cycle(1, 1, 2'b00, 0);
    // reset abandons an outstanding miss
    cycle(1, 0, 2'b00, 0);
    do_reset();
    cycle(0, 1, 2'b00, 0);
    // saturation of the narrow counter
    cycle(1, 1, 2'b00, 0);
    for (int i = 0; i < 20; i++) cycle(1, 0, 2'b00, 0);
    chk("sat4_stall_cnt", {28'd0, stl_b}, 32'd15);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit [1:0] pe;
      int       p;
      if ($urandom_range(0, 399) == 0) do_reset();
      p  = $urandom_range(0, 99);
      pe = (p < 80) ? 2'b00 : (p < 89) ? 2'b01 : (p < 98) ? 2'b10 : 2'b11;
      cycle($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7, pe, $urandom_range(0, 99) < 15);
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter CNT_WIDTH, default 16, width of both saturating performance counters.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 trigger  input  1  run enable (level); 1 = fetch, 0 = halt.
REQ-005 imem_ready  input  1  instruction memory has returned the word for the outstanding request this cycle.
REQ-006 pcsrc_e  input  2  redirect request from execute: 00 none, 01 branch/jal, 10 jalr, 11 illegal.
REQ-007 load_use  input  1  decode load-use hazard.
REQ-008 pcsrc  output  2  select for the PC mux: 00 pc+4, 01 pce+immexte, 10 aluresult.
REQ-009 pc_en  output  1  PC register write enable.
REQ-010 imem_req  output  1  fetch request at current PC.
REQ-011 stall_d  output  1  hold the IF/ID register.
REQ-012 flush_d  output  1  bubble the IF/ID register.
REQ-013 flush_e  output  1  bubble the ID/EX register.
REQ-014 redirect_cnt  output  CNT_WIDTH  redirects taken.
REQ-015 stall_cnt  output  CNT_WIDTH  cycles with pc_en=0 in FETCH.
REQ-016 err  output  1  sticky illegal-pcsrc_e flag.

Function
REQ-017 The FSM SHALL have states IDLE, FETCH and DRAIN, plus a 1-bit halt_pending register.
REQ-018 IDLE: imem_req=0, pc_en=0, pcsrc=00, flush_d=1, flush_e=1; trigger=1 -> FETCH next cycle.
REQ-019 FETCH: imem_req=1; priority order: redirect, then imem miss, then load_use, then normal.
REQ-020 Redirect (pcsrc_e 01/10 in FETCH): pcsrc=pcsrc_e, pc_en=1, flush_d=1, flush_e=1; if imem_ready=0 -> DRAIN, else stay FETCH; redirect_cnt +1.
REQ-021 Miss (no redirect, imem_ready=0): pc_en=0, stall_d=1; stay FETCH; stall_cnt +1.
REQ-022 Load-use (no redirect, imem_ready=1, load_use=1): pc_en=0, stall_d=1, flush_e=1; stall_cnt +1.
REQ-023 Normal: pcsrc=00, pc_en=1, all stall/flush 0.
REQ-024 DRAIN: imem_req=0, pc_en=0, flush_d=1; discard response; on imem_ready -> IDLE if halt_pending, else FETCH; clear halt_pending.
REQ-025 trigger=0 in FETCH with no redirect: imem_ready=1 -> IDLE, pc_en=0; imem_ready=0 -> DRAIN, halt_pending=1.
REQ-026 trigger=0 coincident with redirect: redirect completes (PC updated), then halt path of REQ-025 applies to the same cycle's imem_ready.
REQ-027 pcsrc_e=11 SHALL be treated as 00 and set err until reset.
REQ-028 Counters SHALL saturate at all-ones, never wrap.
REQ-029 All outputs except counters and err SHALL be combinational from state and inputs; zero-cycle latency to the PC mux.

Reset
REQ-030 rst_n low SHALL immediately force state=IDLE, halt_pending=0, counters=0, err=0; thus pc_en=0, imem_req=0, pcsrc=00, flush_d=1, flush_e=1, stall_d=0.
REQ-031 Reset mid-DRAIN or mid-miss SHALL abandon the outstanding request; a late imem_ready in IDLE is ignored.

Structure
REQ-032 A shared package fetch_pkg SHALL hold the state enum and PCSRC_PLUS4=00, PCSRC_BRANCH=01, PCSRC_JALR=10.
REQ-033 One sub-module sat_counter (parameter WIDTH, inc, count) SHALL be instantiated twice.

Verification
REQ-034 Reset released, trigger=1, imem_ready=1 for 5 cycles -> pc_en=1, pcsrc=00 on 5 cycles after the IDLE cycle; stall_cnt=0.
REQ-035 In FETCH, imem_ready=0 for 3 cycles -> pc_en=0, stall_d=1 for 3 cycles; stall_cnt=3.
REQ-036 pcsrc_e=10 with imem_ready=0 -> pcsrc=10, pc_en=1, flush_d=flush_e=1; next cycle DRAIN, imem_req=0; imem_ready -> FETCH; redirect_cnt=1.
REQ-037 load_use=1 and pcsrc_e=01 same cycle -> redirect wins: pc_en=1, pcsrc=01; stall_cnt unchanged.
REQ-038 trigger drops during miss -> DRAIN, then IDLE on imem_ready; pcsrc_e=11 any time -> err=1 held until rst_n low.
REQ-039 CNT_WIDTH=4, 20 miss cycles -> stall_cnt=15.
